// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - frequency-sweep scheduler driving the DDS tuning word and its write strobe
module dds_sweep_ctrl #(
    parameter int FCW_W   = 32,
    parameter int CNT_W   = 12,
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_cont,
    input  logic [FCW_W-1:0]   i_fcw_start,
    input  logic [FCW_W-1:0]   i_fcw_step,
    input  logic [CNT_W-1:0]   i_num_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [FCW_W-1:0]   o_fcw,
    output logic               o_fcw_we,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_point
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t             state, state_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [FCW_W-1:0]   fcw_nx;
    logic [CNT_W-1:0]   point_nx;
    logic               we_nx, busy_nx, done_nx, latch;

    logic [FCW_W-1:0]   sh_start, sh_step;
    logic [CNT_W-1:0]   sh_n;
    logic [DWELL_W-1:0] sh_dm1;
    logic               sh_cont;
    logic [DWELL_W-1:0] dwell_m1;

    // A dwell of 0 behaves as 1, so the reload value saturates at zero.
    assign dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_fcw    <= '0;
            o_fcw_we <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_point  <= '0;
            sh_start <= '0;
            sh_step  <= '0;
            sh_n     <= '0;
            sh_dm1   <= '0;
            sh_cont  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            o_fcw    <= fcw_nx;
            o_fcw_we <= we_nx;
            o_busy   <= busy_nx;
            o_done   <= done_nx;
            o_point  <= point_nx;
            if (latch) begin
                sh_start <= i_fcw_start;
                sh_step  <= i_fcw_step;
                sh_n     <= i_num_steps;
                sh_dm1   <= dwell_m1;
                sh_cont  <= i_cont;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fcw_nx   = o_fcw;
        point_nx = o_point;
        we_nx    = 1'b0;
        busy_nx  = o_busy;
        done_nx  = 1'b0;
        latch    = 1'b0;

        if (i_abort) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        latch    = 1'b1;
                        fcw_nx   = i_fcw_start;
                        point_nx = '0;
                        we_nx    = 1'b1;
                        busy_nx  = 1'b1;
                        cnt_nx   = dwell_m1;
                        state_nx = DWELL;
                    end
                end
                DWELL: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - 1'b1;
                    end else if (o_point < sh_n) begin
                        fcw_nx   = o_fcw + sh_step;
                        point_nx = o_point + 1'b1;
                        we_nx    = 1'b1;
                        cnt_nx   = sh_dm1;
                    end else if (sh_cont) begin
                        fcw_nx   = sh_start;
                        point_nx = '0;
                        we_nx    = 1'b1;
                        cnt_nx   = sh_dm1;
                    end else begin
                        done_nx  = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed scoreboard bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, cont;
    logic [31:0] fcw_start, fcw_step;
    logic [11:0] num_steps;
    logic [15:0] dwell;
    logic [31:0] fcw;
    logic        fcw_we, busy, done;
    logic [11:0] point;

    dds_sweep_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_cont(cont),
        .i_fcw_start(fcw_start), .i_fcw_step(fcw_step), .i_num_steps(num_steps), .i_dwell(dwell),
        .o_fcw(fcw), .o_fcw_we(fcw_we), .o_busy(busy), .o_done(done), .o_point(point)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fcw;
        logic [11:0] point;
        int          cyc;
        logic        is_done;
    } ev_t;

    ev_t q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    int  t0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare whatever the DUT produced against the scoreboard head.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_event_cyc", 64'(cyc), 64'(q[0].cyc));
            void'(q.pop_front());
        end
        chk("we_done_exclusive", {63'd0, fcw_we & done}, 64'd0);
        if (fcw_we || done) begin
            if (q.size() == 0) begin
                chk("unexpected_event_cyc", 64'(cyc), '1);
            end else begin
                e = q.pop_front();
                chk("event_is_done", {63'd0, done}, {63'd0, e.is_done});
                chk("event_fcw", {32'd0, fcw}, {32'd0, e.fcw});
                chk("event_point", {52'd0, point}, {52'd0, e.point});
                chk("event_cyc", 64'(cyc), 64'(e.cyc));
                if (done) chk("busy_at_done", {63'd0, busy}, 64'd0);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Called at a negedge; pulses i_start for one edge and queues the expected strobes (and done).
    task automatic start_sweep(input logic [31:0] st, input logic [31:0] stp, input int n,
                               input int dw, input logic c, input int npts, input logic with_done,
                               output int t_first);
        ev_t         e;
        logic [31:0] f;
        logic [31:0] last;
        int          p, t, d;
        fcw_start = st;
        fcw_step  = stp;
        num_steps = 12'(n);
        dwell     = 16'(dw);
        cont      = c;
        start     = 1'b1;
        d = (dw == 0) ? 1 : dw;
        t_first = cyc + 1;
        f = st;
        last = st;
        p = 0;
        t = t_first;
        for (int i = 0; i < npts; i++) begin
            e.fcw = f; e.point = 12'(p); e.cyc = t; e.is_done = 1'b0;
            q.push_back(e);
            last = f;
            t += d;
            if (p == n) begin
                p = 0;
                f = st;
            end else begin
                p++;
                f = f + stp;
            end
        end
        if (with_done) begin
            e.fcw = last; e.point = 12'(n); e.cyc = t; e.is_done = 1'b1;
            q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
        fcw_start = '0; fcw_step = '0; num_steps = '0; dwell = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_fcw", {32'd0, fcw}, 64'd0);
        chk("reset_we", {63'd0, fcw_we}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_point", {52'd0, point}, 64'd0);
        rst_n = 1'b1;
        ticks(2);

        // single-shot 4 points, dwell 4
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 4, 1'b1, t0);
        chk("s1_busy_first", {63'd0, busy}, 64'd1);
        drain(40);
        chk("s1_done_cyc", 64'(cyc), 64'(t0 + 16));
        tick();
        chk("s1_busy_after", {63'd0, busy}, 64'd0);
        chk("s1_fcw_hold", {32'd0, fcw}, 64'h1300_0000);
        ticks(3);

        // continuous: wraps to start without done, then abort
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b1, 10, 1'b0, t0);
        drain(60);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s2_busy_abort", {63'd0, busy}, 64'd0);
        ticks(12);

        // dwell 0 with wrap-around in both directions
        start_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 0, 1'b0, 3, 1'b1, t0);
        drain(10);
        ticks(2);
        start_sweep(32'h0000_0080, 32'hFFFF_FF00, 2, 0, 1'b0, 3, 1'b1, t0);
        drain(10);
        ticks(2);

        // abort mid-sweep holds word and index
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 2, 1'b0, t0);
        ticks(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_busy", {63'd0, busy}, 64'd0);
        chk("s4_fcw", {32'd0, fcw}, 64'h1100_0000);
        chk("s4_point", {52'd0, point}, 64'd1);
        ticks(20);
        chk("s4_queue_empty", 64'(q.size()), 64'd0);

        // start together with abort in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        ticks(6);
        chk("s4b_busy", {63'd0, busy}, 64'd0);

        // mid-sweep start and config changes are ignored
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 4, 1'b1, t0);
        ticks(4);
        start = 1'b1; fcw_step = 32'h7; dwell = 16'd9; num_steps = 12'd1; cont = 1'b1;
        tick();
        start = 1'b0;
        drain(40);
        tick();
        chk("s5_busy_after", {63'd0, busy}, 64'd0);
        ticks(3);

        // asynchronous reset mid-sweep
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 2, 1'b0, t0);
        ticks(5);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_fcw", {32'd0, fcw}, 64'd0);
        chk("s6_rst_we", {63'd0, fcw_we}, 64'd0);
        chk("s6_rst_busy", {63'd0, busy}, 64'd0);
        chk("s6_rst_done", {63'd0, done}, 64'd0);
        chk("s6_rst_point", {52'd0, point}, 64'd0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        start_sweep(32'h1000_0000, 32'h0100_0000, 3, 4, 1'b0, 4, 1'b1, t0);
        drain(40);
        ticks(3);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
